// File: rtl/mux_scan_pkg.sv
// mux_scan_pkg: shared states, geometry and counter-width helper for the mux scan controller
package mux_scan_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, VALID = 2'd2} state_t;
  localparam int NUM_BANKS = 4;
  localparam int LANES     = 4;
  localparam int FRAME_W   = 16;
  localparam int DWELL_MAX = 16;
  function automatic int cnt_w(input int d);
    return d > 1 ? $clog2(d) : 1;
  endfunction
endpackage

// File: rtl/mux_scan_ctrl_if.sv
// mux_scan_ctrl_if: scan-controller bus; frame_parity exists only with SCAN_PARITY_EN
interface mux_scan_ctrl_if;
  logic        start;
  logic [1:0]  selector;
  logic        y0, y1, y2, y3;
  logic [15:0] frame;
  logic        frame_valid;
  logic        frame_ready;
  logic        busy;
`ifdef SCAN_PARITY_EN
  logic        frame_parity;
`endif
  modport slave (
    input  start, y0, y1, y2, y3, frame_ready,
    output selector, frame, frame_valid, busy
`ifdef SCAN_PARITY_EN
    , frame_parity
`endif
  );
  modport master (
    output start, y0, y1, y2, y3, frame_ready,
    input  selector, frame, frame_valid, busy
`ifdef SCAN_PARITY_EN
    , frame_parity
`endif
  );
endinterface

// File: rtl/mux_scan_dwell_cnt.sv
// mux_scan_dwell_cnt: per-bank dwell counter with bank index and last-cycle strobe
module mux_scan_dwell_cnt
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_clr,
  input  logic                         i_en,
  output logic [$clog2(NUM_BANKS)-1:0] o_bank,
  output logic                         o_last
);
  localparam int CW = cnt_w(DWELL);
  logic [CW-1:0]                r_dwell;
  logic [$clog2(NUM_BANKS)-1:0] r_bank;
  assign o_bank = r_bank;
  assign o_last = i_en && r_dwell == CW'(DWELL - 1);
  // bank only rolls over on the final capture, which also ends the scan
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_dwell <= '0;
      r_bank  <= '0;
    end else if (o_last) begin
      r_dwell <= '0;
      r_bank  <= r_bank + 1'b1;
    end else if (i_en) begin
      r_dwell <= r_dwell + 1'b1;
    end
  end
endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: scans four mux banks into a 16-bit frame with valid/ready output
// SCAN_PARITY_EN adds a registered frame_parity output
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int DWELL = 1
) (
  input logic            clk,
  input logic            rst,
  mux_scan_ctrl_if.slave bus
);
  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SCAN  = SCAN;
  localparam logic [1:0] ST_VALID = VALID;
  logic [1:0]         r_state, w_next, w_bank;
  logic               w_last, w_hs, w_clr;
  logic [FRAME_W-1:0] r_frame, w_frame;
  assign w_hs  = r_state == ST_VALID && bus.frame_ready;
  assign w_clr = bus.start && (r_state == ST_IDLE || w_hs);
  mux_scan_dwell_cnt #(.DWELL(DWELL)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_en   (r_state == ST_SCAN),
    .o_bank (w_bank),
    .o_last (w_last)
  );
  always_comb begin
    w_next = r_state == ST_IDLE ? (bus.start ? ST_SCAN : ST_IDLE) :
             r_state == ST_SCAN ? (w_last && w_bank == 2'd3 ? ST_VALID : ST_SCAN) :
             w_hs               ? (bus.start ? ST_SCAN : ST_IDLE) : ST_VALID;
    w_frame = r_frame;
    if (w_last) w_frame[w_bank*LANES +: LANES] = {bus.y3, bus.y2, bus.y1, bus.y0};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_frame <= '0;
    end else begin
      r_state <= w_next;
      r_frame <= w_frame;
    end
  end
`ifdef SCAN_PARITY_EN
  logic r_parity;
  always_ff @(posedge clk) r_parity <= rst ? 1'b0 : ^w_frame;
  assign bus.frame_parity = r_parity;
`endif
  assign bus.selector    = r_state == ST_SCAN ? w_bank : 2'd0;
  assign bus.frame       = r_frame;
  assign bus.frame_valid = r_state == ST_VALID;
  assign bus.busy        = r_state != ST_IDLE;
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl: directed and random checks of DWELL=1 and DWELL=3 instances against a timing model
module tb_mux_scan_ctrl;
  logic        clk, rst, start, ready;
  logic [3:0]  pat [4];
  logic [3:0]  yn1, yn3;
  int          n_tests = 0, n_fail = 0;
  int          dw [2] = '{1, 3};
  int          m_mode [2] = '{0, 0};
  int          m_t [2] = '{0, 0};
  logic [15:0] m_frame [2] = '{16'h0, 16'h0};

  mux_scan_ctrl_if b1 ();
  mux_scan_ctrl_if b3 ();
  assign b1.start = start;
  assign b3.start = start;
  assign b1.frame_ready = ready;
  assign b3.frame_ready = ready;
  assign yn1 = pat[b1.selector];
  assign yn3 = pat[b3.selector];
  assign {b1.y3, b1.y2, b1.y1, b1.y0} = yn1;
  assign {b3.y3, b3.y2, b3.y1, b3.y0} = yn3;

  mux_scan_ctrl #(.DWELL(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  mux_scan_ctrl #(.DWELL(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // mode 0 idle, 1 scanning (t = cycles since start edge), 2 frame waiting
  task automatic model_upd(input int d);
    int nib;
    if (rst) begin
      m_mode[d] = 0; m_t[d] = 0; m_frame[d] = 16'h0;
    end else if (m_mode[d] == 0) begin
      if (start) begin m_mode[d] = 1; m_t[d] = 0; end
    end else if (m_mode[d] == 1) begin
      nib = m_t[d] / dw[d];
      if (m_t[d] % dw[d] == dw[d] - 1) m_frame[d][nib*4 +: 4] = pat[nib];
      m_t[d]++;
      if (m_t[d] == 4 * dw[d]) m_mode[d] = 2;
    end else if (ready) begin
      m_mode[d] = start ? 1 : 0; m_t[d] = 0;
    end
  endtask

  function automatic logic [15:0] esel(input int d);
    return m_mode[d] == 1 ? 16'(m_t[d] / dw[d]) : 16'h0;
  endfunction

  task automatic check_all();
    chk("sel_d1", 16'(b1.selector), esel(0));
    chk("frame_d1", b1.frame, m_frame[0]);
    chk("valid_d1", 16'(b1.frame_valid), 16'(m_mode[0] == 2));
    chk("busy_d1", 16'(b1.busy), 16'(m_mode[0] != 0));
    chk("sel_d3", 16'(b3.selector), esel(1));
    chk("frame_d3", b3.frame, m_frame[1]);
    chk("valid_d3", 16'(b3.frame_valid), 16'(m_mode[1] == 2));
    chk("busy_d3", 16'(b3.busy), 16'(m_mode[1] != 0));
`ifdef SCAN_PARITY_EN
    chk("par_d1", 16'(b1.frame_parity), 16'(^m_frame[0]));
    chk("par_d3", 16'(b3.frame_parity), 16'(^m_frame[1]));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_upd(0);
    model_upd(1);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_pat(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] e);
    pat[0] = a; pat[1] = b; pat[2] = c; pat[3] = e;
  endtask

  initial begin
    rst = 1; start = 0; ready = 0;
    set_pat(4'hA, 4'h5, 4'hF, 4'h3);
    tick(); tick();
    chk("reset_frame", b3.frame, 16'h0000);
    rst = 0;
    tick();
    start = 1; tick(); start = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 2) chk("lat_pre_d1", 16'(b1.frame_valid), 16'h0);
      if (i == 3) chk("lat_d1", 16'(b1.frame_valid), 16'h1);
      if (i == 10) chk("lat_pre_d3", 16'(b3.frame_valid), 16'h0);
      if (i == 11) chk("lat_d3", 16'(b3.frame_valid), 16'h1);
    end
    chk("scan_d1", b1.frame, 16'h3F5A);
    chk("scan_d3", b3.frame, 16'h3F5A);
`ifdef SCAN_PARITY_EN
    chk("par_3f5a", 16'(b1.frame_parity), 16'h0);
`endif
    for (int i = 0; i < 10; i++) begin
      set_pat(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      start = 1'($urandom);
      tick();
    end
    chk("bp_frame_d1", b1.frame, 16'h3F5A);
    chk("bp_frame_d3", b3.frame, 16'h3F5A);
    chk("bp_valid_d3", 16'(b3.frame_valid), 16'h1);
    set_pat(4'hA, 4'h5, 4'hF, 4'h3);
    start = 1; ready = 1; tick(); start = 0; ready = 0;
    chk("b2b_busy", 16'(b3.busy), 16'h1);
    chk("b2b_sel", 16'(b3.selector), 16'h0);
    chk("b2b_valid", 16'(b3.frame_valid), 16'h0);
    for (int i = 0; i < 12; i++) tick();
    ready = 1; tick(); ready = 0;
    chk("idle_busy", 16'(b3.busy), 16'h0);
    set_pat(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
    start = 1; tick(); start = 0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_bank2", 16'(b3.selector), 16'h2);
    rst = 1; tick(); rst = 0;
    chk("rst_frame", b3.frame, 16'h0000);
    chk("rst_busy", 16'(b3.busy), 16'h0);
    chk("rst_sel", 16'(b3.selector), 16'h0);
    set_pat(4'hB, 4'h5, 4'hF, 4'h3);
    start = 1; tick(); start = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("clean_d3", b3.frame, 16'h3F5B);
`ifdef SCAN_PARITY_EN
    chk("par_3f5b", 16'(b3.frame_parity), 16'h1);
`endif
    ready = 1; tick(); ready = 0;
    for (int i = 0; i < 400; i++) begin
      set_pat(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
      start = ($urandom % 4) == 0;
      ready = 1'($urandom);
      rst   = ($urandom % 60) == 0;
      tick();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 Parameter: DWELL, default 1, cycles the selector is held per bank before sampling; legal range 1..16.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: start  input  1  request one scan of all four banks; sampled only in IDLE or on a completing handshake.
REQ-005 Port: selector  output  2  bank select driven to the 16:4 mux stage.
REQ-006 Port: y0, y1, y2, y3  input  1 each  mux stage outputs for the currently selected bank.
REQ-007 Port: frame  output  16  captured snapshot; bits [4k+3:4k] = {y3,y2,y1,y0} of bank k.
REQ-008 Port: frame_valid  output  1  frame holds a complete scan.
REQ-009 Port: frame_ready  input  1  consumer accepts frame.
REQ-010 Port: busy  output  1  high in SCAN or VALID.

Function
REQ-011 The FSM SHALL have states IDLE, SCAN, VALID.
REQ-012 In IDLE, start=1 at an edge SHALL enter SCAN, with bank=0 and the dwell count cleared.
REQ-013 In IDLE, selector SHALL be 0.
REQ-014 In SCAN, selector SHALL equal the current bank index (0..3).
REQ-015 The dwell counter SHALL count 0..DWELL-1 per bank.
REQ-016 On the edge ending the DWELL-th cycle of a bank, the block SHALL capture {y3,y2,y1,y0} into frame nibble [bank].
REQ-017 After a capture, bank SHALL increment and the dwell counter SHALL clear.
REQ-018 The capture of bank 3 SHALL transition to VALID.
REQ-019 frame_valid SHALL rise exactly 4*DWELL cycles after the edge that sampled start.
REQ-020 In VALID, frame and frame_valid SHALL hold stable until frame_valid & frame_ready at an edge.
REQ-021 On the handshake edge with start=0, the FSM SHALL go to IDLE and frame_valid SHALL drop.
REQ-022 On the handshake edge with start=1, the FSM SHALL enter SCAN bank 0 directly (back-to-back scans, no IDLE cycle).
REQ-023 start SHALL be ignored in SCAN, and in VALID without a handshake.
REQ-024 Nibbles not yet recaptured during a new scan SHALL retain the previous values.
REQ-025 frame_ready SHALL be ignored outside VALID.
REQ-026 bank SHALL never exceed 3, with no wrap-around inside a scan.
REQ-027 The dwell counter width SHALL be the minimum needed for DWELL-1, with at least 1 bit.

Reset
REQ-028 rst=1 at an edge SHALL force: state=IDLE, selector=0, frame=16'h0000, frame_valid=0, busy=0, bank=0, dwell=0.
REQ-029 Reset SHALL take priority over start and over the handshake in every state, including mid-SCAN and in VALID.
REQ-030 Any partial frame SHALL be discarded on reset.

Configuration
REQ-031 With SCAN_PARITY_EN defined, output frame_parity (1 bit) SHALL exist, equal to the XOR of all 16 frame bits.
REQ-032 frame_parity SHALL be registered together with frame (updated on each nibble capture, 0 on reset), and valid whenever frame_valid=1.
REQ-033 Without SCAN_PARITY_EN, the frame_parity port and its logic SHALL be absent; all other behaviour is unchanged.

Structure
REQ-034 Package mux_scan_pkg SHALL hold: state enum (IDLE, SCAN, VALID), NUM_BANKS=4, LANES=4, FRAME_W=16, DWELL_MAX=16.
REQ-035 The dwell/bank counter SHALL be a single sub-module, mux_scan_dwell_cnt, producing bank index and last-cycle strobe.
REQ-036 All other logic SHALL reside in mux_scan_ctrl.

Verification
REQ-037 Scan, DWELL=1: y driven per selector as 0:4'hA, 1:4'h5, 2:4'hF, 3:4'h3; start pulse -> selector 0,1,2,3 on successive cycles; frame=16'h3F5A, frame_valid 4 cycles after start edge.
REQ-038 DWELL=3: same stimulus -> each selector value held 3 cycles; frame_valid at cycle 12; frame=16'h3F5A.
REQ-039 Backpressure: frame_ready=0 for 10 cycles in VALID, with y changed -> frame stays 16'h3F5A; frame_valid stays 1; start ignored.
REQ-040 Back-to-back: start=1 and frame_ready=1 on the same edge -> next cycle busy=1, selector=0, frame_valid=0.
REQ-041 Reset mid-scan: rst during bank 2 -> next cycle state IDLE, frame=16'h0000, selector=0, busy=0; a new start gives a clean frame.
REQ-042 SCAN_PARITY_EN: frame 16'h3F5A -> frame_parity=0; frame 16'h3F5B -> frame_parity=1.
